pcie_tlp_req_queue: RTL and testbench
=====================================

// Module: pcie_tlp_req_queue
// PURPOSE
//  Parametrised successor to the single-request TLP decoder. It accepts single-beat memory
//  request TLPs (3DW and 4DW headers) from the PCIe RX stream and decodes MRd/MWr fields.
//  Decoded requests are queued in a DEPTH-entry FIFO and presented on a valid/ready port to
//  the register/VRAM access logic. Back-pressure goes upstream. Unsupported TLPs are dropped and counted.
// PARAMETERS
//  ADDR_W  16  request address bits output; taken from the LSBs of the DW-aligned address
//  DEPTH   4   request FIFO entries; power of 2, >=2
//  CNT_W   16  width of the saturating drop counter
// PORTS
//  clk            in   1      clock; everything on rising edge
//  rst            in   1      synchronous reset, active-high
//  rx_data        in   256    TLP beat; DW0=[255:224], DW1=[223:192], DW2=[191:160], DW3=[159:128], DW4=[127:96]
//  rx_valid       in   1      beat valid
//  rx_sop         in   1      first beat of TLP
//  rx_eop         in   1      last beat of TLP
//  rx_ready       out  1      beat consumed when rx_valid&rx_ready
//  req_valid      out  1      FIFO head valid
//  req_ready      in   1      consumer pops head when req_valid&req_ready
//  req_is_write   out  1      1=MWr, 0=MRd
//  req_addr       out  ADDR_W byte address, [1:0]=0
//  req_data       out  32     write data (0 for reads)
//  req_first_be   out  4      DW1[3:0]
//  req_last_be    out  4      DW1[7:4]
//  req_len        out  11     length in DW, 1..1024 (field 0 -> 1024)
//  req_tag        out  8      DW1[15:8]
//  req_requester  out  16     DW1[31:16]
//  drop_cnt       out  CNT_W  dropped-TLP count, saturates at all-ones
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, drop_cnt=0, req_valid=0, all req_* outputs 0.
//  rx_ready = (state==DISCARD) | ~fifo_full. It is combinational from registered state only.
//  Decode, DW0: fmt=[31:29], type=[28:24], EP=[14], len=[9:0].
//    fmt 000/001 with type 00000 = MRd (3DW/4DW).
//    fmt 010/011 with type 00000 = MWr (3DW/4DW).
//  Address: 3DW uses DW2. 4DW uses DW3 (the lower 32 bits); DW2 is ignored.
//  Data: 3DW MWr uses DW3. 4DW MWr uses DW4.
//  Supported request: a beat with valid&ready&sop&eop that decodes as MRd (any len), or as MWr with
//    len==1 and EP==0. It is pushed to the FIFO on that edge.
//  Every other sop beat is dropped and increments drop_cnt by 1. This covers other fmt/type, poisoned
//    MWr, MWr with len!=1, and sop without eop.
//  FSM:
//    IDLE -> DISCARD on an accepted sop beat without eop.
//    DISCARD consumes beats (rx_ready=1) until the beat with eop, then returns to IDLE.
//    Beats with valid and no sop in IDLE are consumed and ignored. They are not counted.
//  Latency: request accepted at edge N; visible on req_* at N+1 (req_valid=1) when the FIFO was empty.
//  FIFO: first-word-fall-through, registered. req_* show the head entry and are 0 when empty.
//  Push and pop on the same edge are both honoured and the count is unchanged.
//  When full, rx_ready=0 in IDLE. No request is ever lost or overwritten.
//  Pointers wrap modulo DEPTH. The count is held in log2(DEPTH)+1 bits.
//  drop_cnt holds at 2^CNT_W-1.
//  Reset mid-operation: FIFO contents and DISCARD state are abandoned. The next beat must carry sop.
// TESTING
//  T1: 3DW MWr: DW0=0x40000001, DW1=0x12340A0F, DW2=0x00001230, DW3=0xDEADBEEF
//      -> next cycle req_valid=1, is_write=1, addr=0x1230, data=0xDEADBEEF, first_be=0xF,
//         last_be=0x0, tag=0x0A, requester=0x1234, len=1.
//  T2: 4DW MRd: DW0=0x20000000, DW2=0x00000001, DW3=0x0000ABC4
//      -> is_write=0, addr=0xABC4, len=1024, data=0.
//  T3: req_ready=0, send DEPTH+2 valid MWr
//      -> rx_ready drops after DEPTH pushes; raise req_ready and all DEPTH+2 requests drain in order.
//  T4: 3-beat TLP (sop, mid, eop) then a valid MRd
//      -> drop_cnt=1, no push for the long TLP, the MRd is queued.
//  T5: MWr with EP=1 (DW0=0x40004001), then MWr len=2, then Cpl (DW0=0x4A000001)
//      -> drop_cnt=3, FIFO empty.
//  T6: 2 requests queued, assert rst for 1 cycle
//      -> req_valid=0, drop_cnt=0, rx_ready=1 on the next cycle.

Source files
------------

// File: rtl/pcie_tlp_req_queue.sv
// Decodes single-beat MRd/MWr TLPs from the PCIe RX stream into a FWFT request FIFO.
// Unsupported or multi-beat TLPs are consumed, discarded and counted.
module pcie_tlp_req_queue #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [255:0]      rx_data_i,
  input  logic              rx_valid_i,
  input  logic              rx_sop_i,
  input  logic              rx_eop_i,
  output logic              rx_ready_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_is_write_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [31:0]       req_data_o,
  output logic [3:0]        req_first_be_o,
  output logic [3:0]        req_last_be_o,
  output logic [10:0]       req_len_o,
  output logic [7:0]        req_tag_o,
  output logic [15:0]       req_requester_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + 76;
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [31:0]      dw0, dw1, dw2, dw3, dw4;
  logic [31:0]      addr_dw, wdata;
  logic [10:0]      len_dw;
  logic             is_mrd, is_mwr, supported;
  logic             rx_fire, push, pop, drop, full;
  logic [ENT_W-1:0] new_entry, head;
  logic             unused_ok;

  assign dw0 = rx_data_i[255:224];
  assign dw1 = rx_data_i[223:192];
  assign dw2 = rx_data_i[191:160];
  assign dw3 = rx_data_i[159:128];
  assign dw4 = rx_data_i[127:96];
  assign unused_ok = ^{rx_data_i[95:0], dw0, addr_dw};

  // Field decode of the current beat and the FIFO entry it would produce
  always_comb begin
    is_mrd    = (dw0[31:30] == 2'b00) && (dw0[28:24] == 5'b00000);
    is_mwr    = (dw0[31:30] == 2'b01) && (dw0[28:24] == 5'b00000);
    supported = is_mrd | (is_mwr && (dw0[9:0] == 10'd1) && !dw0[14]);
    addr_dw   = dw0[29] ? dw3 : dw2;
    if (is_mwr) begin
      wdata = dw0[29] ? dw4 : dw3;
    end else begin
      wdata = 32'h0000_0000;
    end
    // A zero length field encodes the maximum of 1024 DW
    if (dw0[9:0] == 10'd0) begin
      len_dw = 11'd1024;
    end else begin
      len_dw = {1'b0, dw0[9:0]};
    end
    new_entry = {is_mwr, addr_dw[ADDR_W-1:2], 2'b00, wdata, dw1[3:0], dw1[7:4],
                 len_dw, dw1[15:8], dw1[31:16]};
  end

  assign full       = (count_q == FULL_CNT);
  assign rx_ready_o = (state_q == ST_DISCARD) | ~full;
  assign rx_fire    = rx_valid_i & rx_ready_o;
  assign push       = rx_fire & (state_q == ST_IDLE) & rx_sop_i & rx_eop_i & supported;
  assign drop       = rx_fire & (state_q == ST_IDLE) & rx_sop_i & ~(rx_eop_i & supported);
  assign req_valid_o = (count_q != {(PTR_W+1){1'b0}});
  assign pop        = req_valid_o & req_ready_i;
  assign head       = mem_q[rd_ptr_q];

  // Next-state for FSM, pointers, occupancy and drop counter
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_fire && rx_sop_i && !rx_eop_i) begin
          state_d = ST_DISCARD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (rx_fire && rx_eop_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (push) begin
      wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {(PTR_W+1){1'b0}};
      drop_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry storage; contents are only observed through a non-zero count
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // Head presentation, forced to zero while the FIFO is empty
  always_comb begin
    if (req_valid_o) begin
      {req_is_write_o, req_addr_o, req_data_o, req_first_be_o, req_last_be_o,
       req_len_o, req_tag_o, req_requester_o} = head;
    end else begin
      {req_is_write_o, req_addr_o, req_data_o, req_first_be_o, req_last_be_o,
       req_len_o, req_tag_o, req_requester_o} = {ENT_W{1'b0}};
    end
  end

  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_pcie_tlp_req_queue.sv
// Scoreboard bench for pcie_tlp_req_queue: expected requests are queued at stimulus
// time and compared field by field when the DUT pops its head.
module tb_pcie_tlp_req_queue;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic        w;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [10:0] len;
    logic [7:0]  tag;
    logic [15:0] rq;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [255:0]      rx_data;
  logic              rx_valid, rx_sop, rx_eop, rx_ready;
  logic              req_valid, req_ready, req_is_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [3:0]        req_first_be, req_last_be;
  logic [10:0]       req_len;
  logic [7:0]        req_tag;
  logic [15:0]       req_requester;
  logic [CNT_W-1:0]  drop_cnt;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   exp_drop = 0;

  pcie_tlp_req_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_sop_i(rx_sop), .rx_eop_i(rx_eop),
    .rx_ready_o(rx_ready),
    .req_valid_o(req_valid), .req_ready_i(req_ready),
    .req_is_write_o(req_is_write), .req_addr_o(req_addr), .req_data_o(req_data),
    .req_first_be_o(req_first_be), .req_last_be_o(req_last_be), .req_len_o(req_len),
    .req_tag_o(req_tag), .req_requester_o(req_requester), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Pop monitor: a head accepted on the coming edge must match the scoreboard front
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("is_write",  {63'd0, req_is_write}, {63'd0, e.w});
        check("addr",      {48'd0, req_addr},     {48'd0, e.addr});
        check("data",      {32'd0, req_data},     {32'd0, e.data});
        check("first_be",  {60'd0, req_first_be}, {60'd0, e.fbe});
        check("last_be",   {60'd0, req_last_be},  {60'd0, e.lbe});
        check("len",       {53'd0, req_len},      {53'd0, e.len});
        check("tag",       {56'd0, req_tag},      {56'd0, e.tag});
        check("requester", {48'd0, req_requester}, {48'd0, e.rq});
      end
    end
  end

  function automatic logic [255:0] mk_beat(input logic [31:0] d0, d1, d2, d3, d4);
    return {d0, d1, d2, d3, d4, 96'd0};
  endfunction

  task automatic note_drop();
    exp_drop = (exp_drop == 15) ? 15 : exp_drop + 1;
  endtask

  task automatic drive_beat(input logic [255:0] d, input logic sop, input logic eop);
    bit ok;
    ok = 1'b0;
    rx_data = d; rx_sop = sop; rx_eop = eop; rx_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("rx_ready_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  // 3DW (even i) or 4DW (odd i) MWr with the expected entry built from the same fields
  task automatic send_mwr(input int i, input logic [15:0] addr, input logic [31:0] data);
    exp_t e;
    logic [31:0] d1;
    d1 = {16'hBEE0 + 16'(i), 8'(i), 4'h0, 4'hF};
    e = '{w: 1'b1, addr: addr, data: data, fbe: 4'hF, lbe: 4'h0, len: 11'd1,
          tag: 8'(i), rq: 16'hBEE0 + 16'(i)};
    exp_q.push_back(e);
    if (i % 2 == 0) begin
      drive_beat(mk_beat(32'h4000_0001, d1, {16'd0, addr}, data, 32'h5555_5555), 1'b1, 1'b1);
    end else begin
      drive_beat(mk_beat(32'h6000_0001, d1, 32'hFFFF_0000, {16'd0, addr}, data), 1'b1, 1'b1);
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !req_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", {63'd0, ok}, 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_drop = 0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; rx_data = 256'd0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_valid", {63'd0, req_valid}, 64'd0);
    check("rst_drop_cnt",  {60'd0, drop_cnt}, 64'd0);
    check("rst_rx_ready",  {63'd0, rx_ready}, 64'd1);
    check("rst_req_len",   {53'd0, req_len}, 64'd0);

    // T1: 3DW MWr, one-cycle latency into an empty FIFO
    e = '{w: 1'b1, addr: 16'h1230, data: 32'hDEADBEEF, fbe: 4'hF, lbe: 4'h0, len: 11'd1,
          tag: 8'h0A, rq: 16'h1234};
    exp_q.push_back(e);
    drive_beat(mk_beat(32'h4000_0001, 32'h1234_0A0F, 32'h0000_1230, 32'hDEAD_BEEF, 32'h0), 1'b1, 1'b1);
    check("t1_latency_valid", {63'd0, req_valid}, 64'd1);

    // T2: 4DW MRd, len field 0 -> 1024, DW2 and DW4 must not leak into the entry
    e = '{w: 1'b0, addr: 16'hABC4, data: 32'h0, fbe: 4'h0, lbe: 4'h0, len: 11'd1024,
          tag: 8'h00, rq: 16'h0000};
    exp_q.push_back(e);
    drive_beat(mk_beat(32'h2000_0000, 32'h0, 32'h0000_0001, 32'h0000_ABC4, 32'hCAFE_F00D), 1'b1, 1'b1);
    req_ready = 1'b1;
    wait_drain();

    // T3: fill to DEPTH with the consumer stalled, then overflow attempts drain in order
    req_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_mwr(i, 16'h0100 + 16'(i * 4), $urandom);
    check("t3_full_rx_ready", {63'd0, rx_ready}, 64'd0);
    check("t3_full_valid",    {63'd0, req_valid}, 64'd1);
    fork
      for (int i = DEPTH; i < DEPTH + 2; i++) send_mwr(i, 16'h0100 + 16'(i * 4), $urandom);
      begin
        repeat (3) @(negedge clk);
        req_ready = 1'b1;
      end
    join
    wait_drain();

    // T4: stray non-sop beat is ignored; 3-beat TLP is dropped once; MRd follows
    drive_beat(mk_beat(32'h4000_0001, 32'h0, 32'h0, 32'h0, 32'h0), 1'b0, 1'b1);
    drive_beat(mk_beat(32'h0000_0001, 32'h0, 32'h0000_0040, 32'h0, 32'h0), 1'b1, 1'b0);
    note_drop();
    drive_beat(mk_beat(32'h0000_0001, 32'h0, 32'h0000_0080, 32'h0, 32'h0), 1'b0, 1'b0);
    drive_beat(mk_beat(32'h0000_0001, 32'h0, 32'h0000_00C0, 32'h0, 32'h0), 1'b0, 1'b1);
    e = '{w: 1'b0, addr: 16'h0200, data: 32'h0, fbe: 4'h3, lbe: 4'hC, len: 11'd2,
          tag: 8'h55, rq: 16'h0101};
    exp_q.push_back(e);
    drive_beat(mk_beat(32'h0000_0002, 32'h0101_55C3, 32'h0000_0203, 32'h0, 32'h0), 1'b1, 1'b1);
    check("t4_drop_cnt", {60'd0, drop_cnt}, 64'(exp_drop));
    wait_drain();

    // T5: poisoned MWr, MWr len 2, completion -> all dropped
    drive_beat(mk_beat(32'h4000_4001, 32'h0, 32'h0000_0010, 32'h1, 32'h0), 1'b1, 1'b1);
    note_drop();
    drive_beat(mk_beat(32'h4000_0002, 32'h0, 32'h0000_0010, 32'h1, 32'h0), 1'b1, 1'b1);
    note_drop();
    drive_beat(mk_beat(32'h4A00_0001, 32'h0, 32'h0, 32'h0, 32'h0), 1'b1, 1'b1);
    note_drop();
    check("t5_drop_cnt", {60'd0, drop_cnt}, 64'(exp_drop));
    check("t5_empty",    {63'd0, req_valid}, 64'd0);

    // T6: reset abandons queued requests and counters
    req_ready = 1'b0;
    send_mwr(0, 16'h0300, 32'h1111_1111);
    send_mwr(1, 16'h0304, 32'h2222_2222);
    pulse_reset();
    check("t6_req_valid", {63'd0, req_valid}, 64'd0);
    check("t6_drop_cnt",  {60'd0, drop_cnt}, 64'd0);
    check("t6_rx_ready",  {63'd0, rx_ready}, 64'd1);
    check("t6_req_addr",  {48'd0, req_addr}, 64'd0);

    // Reset out of DISCARD: the next sop+eop MRd must be queued, not swallowed
    drive_beat(mk_beat(32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'h0), 1'b1, 1'b0);
    pulse_reset();
    e = '{w: 1'b0, addr: 16'h4448, data: 32'h0, fbe: 4'hF, lbe: 4'h0, len: 11'd1,
          tag: 8'h77, rq: 16'h9999};
    exp_q.push_back(e);
    drive_beat(mk_beat(32'h0000_0001, 32'h9999_770F, 32'h1234_4448, 32'h0, 32'h0), 1'b1, 1'b1);
    check("rst_discard_valid", {63'd0, req_valid}, 64'd1);
    req_ready = 1'b1;
    wait_drain();

    // Drop counter saturation at all-ones
    for (int i = 0; i < 17; i++) begin
      drive_beat(mk_beat(32'h4A00_0001, 32'h0, 32'h0, 32'h0, 32'h0), 1'b1, 1'b1);
      note_drop();
    end
    check("sat_drop_cnt", {60'd0, drop_cnt}, 64'(exp_drop));
    check("sat_empty",    {63'd0, req_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
